data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 97 +++++++++
 tb/tb_data_mem_responder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-side memory and MMIO responder for a single-cycle core.
//
// Ports:
//   clk       in   1   sole clock, all state updates on rising edge
//   reset     in   1   synchronous, active-high reset
//   MemWrite  in   1   store request, sampled at rising clk
//   DataAdr   in  32   byte address
//   WriteData in  32   store data
//   ReadData  out 32   load data, combinational from DataAdr
//   Leds      out  8   LED register contents
//   Done      out  1   test finished, sticky
//   Pass      out  1   test verdict, valid while Done=1
//   BusErr    out  1   sticky illegal-store flag
//
// Map: 0x0000_0000-0x0000_03FF RAM (256 words), 0x8000_0000 CYCLE (RO),
// 0x8000_0004 LED (RW), 0x8000_0008 TOHOST (WO), 0x8000_000C STCNT (RO).
// Macro DMEM_CYCLE_CNT_EN enables the free-running CYCLE counter; without it
// 0x8000_0000 behaves as an unmapped address.
module data_mem_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  Leds,
    output logic        Done,
    output logic        Pass,
    output logic        BusErr
);
    logic [31:0] r_ram [0:255];
    logic [31:0] r_stcnt;
    logic [7:0]  r_leds;
    logic        r_done;
    logic        r_pass;
    logic        r_buserr;
    logic        w_ram_sel;
    logic        w_led_sel;
    logic        w_th_sel;
    logic        w_st_sel;
    logic        w_aligned;
    logic        w_we;
    logic        w_ram_we;
    logic        w_bad;
    logic [31:0] w_cyc_rd;
    // MMIO registers are decoded on the word address so DataAdr[1:0] never affects reads.
    assign w_ram_sel = DataAdr[31:10] == 22'h0;
    assign w_led_sel = DataAdr[31:2] == 30'h2000_0001;
    assign w_th_sel  = DataAdr[31:2] == 30'h2000_0002;
    assign w_st_sel  = DataAdr[31:2] == 30'h2000_0003;
    assign w_aligned = DataAdr[1:0] == 2'b00;
    assign w_we      = MemWrite & ~reset;
    assign w_ram_we  = w_we & w_aligned & w_ram_sel;
    // Only RAM, LED and TOHOST accept stores; everything else (including CYCLE) is a bus error.
    assign w_bad     = w_we & (~w_aligned | ~(w_ram_sel | w_led_sel | w_th_sel));
`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] r_cycle;
    logic        w_cyc_sel;
    assign w_cyc_sel = DataAdr[31:2] == 30'h2000_0000;
    assign w_cyc_rd  = w_cyc_sel ? r_cycle : 32'h0;
    always_ff @(posedge clk) begin
        r_cycle <= reset ? 32'h0 : r_cycle + 32'h1;
    end
`else
    assign w_cyc_rd = 32'h0;
`endif
    // RAM has no reset: its contents survive reset and are unspecified at power-up.
    always_ff @(posedge clk) begin
        if (w_ram_we) r_ram[DataAdr[9:2]] <= WriteData;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stcnt  <= 32'h0;
            r_leds   <= 8'h0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_buserr <= 1'b0;
        end else begin
            if (w_ram_we && r_stcnt != 32'hFFFF_FFFF) r_stcnt <= r_stcnt + 32'h1;
            if (w_we && w_aligned && w_led_sel) r_leds <= WriteData[7:0];
            if (w_we && w_aligned && w_th_sel && !r_done && WriteData != 32'h0) begin
                r_done <= 1'b1;
                r_pass <= WriteData == 32'h1;
            end
            if (w_bad) r_buserr <= 1'b1;
        end
    end
    always_comb begin
        ReadData = w_ram_sel ? r_ram[DataAdr[9:2]] :
                   w_led_sel ? {24'h0, r_leds} :
                   w_st_sel  ? r_stcnt : w_cyc_rd;
    end
    assign Leds   = r_leds;
    assign Done   = r_done;
    assign Pass   = r_pass;
    assign BusErr = r_buserr;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic [7:0]  Leds;
    logic        Done;
    logic        Pass;
    logic        BusErr;
    int          n_chk = 0;
    int          n_fail = 0;

    data_mem_responder dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(ReadData), .Leds(Leds), .Done(Done),
        .Pass(Pass), .BusErr(BusErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] dat);
        MemWrite = 1'b1;
        DataAdr = adr;
        WriteData = dat;
        tick();
        MemWrite = 1'b0;
    endtask

    function automatic logic [31:0] rd(input logic [31:0] adr);
        DataAdr = adr;
        return 32'h0;
    endfunction

    task automatic read_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        DataAdr = adr;
        #1;
        check(tag, ReadData, exp);
    endtask

    initial begin
        logic [31:0] cyc_exp;
        tick();
        tick();
        check("rst_leds", {24'h0, Leds}, 32'h0);
        check("rst_done", {31'h0, Done}, 32'h0);
        check("rst_pass", {31'h0, Pass}, 32'h0);
        check("rst_buserr", {31'h0, BusErr}, 32'h0);
        reset = 1'b0;
        // preload RAM, then reset with a store pending: RAM must survive and the store be dropped
        store(32'h0000_0010, 32'h1111_1111);
        store(32'h0000_0000, 32'hCAFE_0000);
        store(32'h0000_0004, 32'h4444_4444);
        read_chk("stcnt_pre", 32'h8000_000C, 32'h3);
        reset = 1'b1;
        store(32'h0000_0010, 32'h5555_5555);
        reset = 1'b0;
        read_chk("ram_after_rst", 32'h0000_0010, 32'h1111_1111);
        read_chk("stcnt_rst", 32'h8000_000C, 32'h0);
        for (int i = 0; i < 10; i++) tick();
`ifdef DMEM_CYCLE_CNT_EN
        cyc_exp = 32'd10;
`else
        cyc_exp = 32'd0;
`endif
        read_chk("cycle_10", 32'h8000_0000, cyc_exp);
        // store with same-cycle read: old data before the edge, new data after
        MemWrite = 1'b1;
        DataAdr = 32'h0000_0010;
        WriteData = 32'hDEAD_BEEF;
        #1;
        check("ram_old", ReadData, 32'h1111_1111);
        tick();
        MemWrite = 1'b0;
        read_chk("ram_new", 32'h0000_0010, 32'hDEAD_BEEF);
        read_chk("ram_unaligned_rd", 32'h0000_0013, 32'hDEAD_BEEF);
        read_chk("stcnt_1", 32'h8000_000C, 32'h1);
        store(32'h8000_0004, 32'h0000_01A5);
        check("leds", {24'h0, Leds}, 32'hA5);
        read_chk("led_rd", 32'h8000_0004, 32'hA5);
        check("buserr_clean", {31'h0, BusErr}, 32'h0);
        store(32'h0000_0402, 32'h9999_9999);
        check("buserr_402", {31'h0, BusErr}, 32'h1);
        store(32'h0000_0800, 32'h8888_8888);
        store(32'h0000_0006, 32'h7777_7777);
        read_chk("ram0_intact", 32'h0000_0000, 32'hCAFE_0000);
        read_chk("ram1_intact", 32'h0000_0004, 32'h4444_4444);
        read_chk("rd_800", 32'h0000_0800, 32'h0);
        read_chk("stcnt_bad", 32'h8000_000C, 32'h1);
        store(32'h8000_0008, 32'h0);
        check("done_zero", {31'h0, Done}, 32'h0);
        store(32'h8000_0008, 32'h1);
        check("done_1", {31'h0, Done}, 32'h1);
        check("pass_1", {31'h0, Pass}, 32'h1);
        store(32'h8000_0008, 32'h2);
        check("pass_sticky", {31'h0, Pass}, 32'h1);
        read_chk("tohost_rd", 32'h8000_0008, 32'h0);
        reset = 1'b1;
        store(32'h8000_0004, 32'h0000_0077);
        reset = 1'b0;
        check("rst_mw_leds", {24'h0, Leds}, 32'h0);
        check("rst_mw_done", {31'h0, Done}, 32'h0);
        check("rst_mw_buserr", {31'h0, BusErr}, 32'h0);
        store(32'h8000_0008, 32'h2);
        check("fail_done", {31'h0, Done}, 32'h1);
        check("fail_pass", {31'h0, Pass}, 32'h0);
        check("buserr_none", {31'h0, BusErr}, 32'h0);
        store(32'h8000_0000, 32'h5);
        check("buserr_cycle", {31'h0, BusErr}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        store(32'h8000_000C, 32'h5);
        check("buserr_stcnt", {31'h0, BusErr}, 32'h1);
        read_chk("stcnt_ro", 32'h8000_000C, 32'h0);
        store(32'h8000_0006, 32'h33);
        check("leds_misaligned", {24'h0, Leds}, 32'h0);
`ifdef DMEM_CYCLE_CNT_EN
        force dut.r_cycle = 32'hFFFF_FFFE;
        #1;
        release dut.r_cycle;
        tick();
        read_chk("cycle_max", 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        read_chk("cycle_wrap", 32'h8000_0000, 32'h0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
